// File: rtl/q_update_engine_if.sv
// Update request/response bundle between the maze environment
// and the Q-learning update engine.
interface q_update_engine_if #(
  parameter int NUM_STATES  = 37,
  parameter int NUM_ACTIONS = 4,
  parameter int DATA_W      = 32
) ();
  localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int AW = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;

  logic                     upd_valid;
  logic                     upd_ready;
  logic [SW-1:0]            upd_state;
  logic [AW-1:0]            upd_action;
  logic [SW-1:0]            upd_next;
  logic signed [DATA_W-1:0] upd_reward;
  logic                     upd_terminal;
  logic                     upd_done;
  logic                     upd_err;
  logic signed [DATA_W-1:0] upd_q;

  modport master (
    output upd_valid, upd_state, upd_action, upd_next,
    output upd_reward, upd_terminal,
    input  upd_ready, upd_done, upd_err, upd_q
  );

  modport slave (
    input  upd_valid, upd_state, upd_action, upd_next,
    input  upd_reward, upd_terminal,
    output upd_ready, upd_done, upd_err, upd_q
  );
endinterface

// File: rtl/q_update_engine.sv
// Multi-cycle Q-learning update engine: register Q-table, serial
// max scan, saturating fixed-point TD update, greedy read port.
module q_update_engine #(
  parameter int          NUM_STATES  = 37,
  parameter int          NUM_ACTIONS = 4,
  parameter int          DATA_W      = 32,
  parameter int          FRAC_W      = 16,
  parameter int unsigned ALPHA       = 13107,
  parameter int unsigned GAMMA       = 58982,
  localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
  localparam int AW = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  q_update_engine_if.slave         upd,
  output logic                     busy,
  input  logic [SW-1:0]            rd_state,
  input  logic [AW-1:0]            rd_action,
  output logic signed [DATA_W-1:0] rd_q,
  output logic [AW-1:0]            rd_best
);

  // Wide enough for coefficient*difference with no intermediate loss
  localparam int PW = 2*DATA_W + 4;

  localparam logic signed [PW-1:0] Q_HI =
    {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] Q_LO    = ~Q_HI;
  localparam logic signed [PW-1:0] ALPHA_X = PW'(ALPHA);
  localparam logic signed [PW-1:0] GAMMA_X = PW'(GAMMA);
  localparam logic [AW-1:0]        CNT_END = AW'(NUM_ACTIONS-1);

  typedef logic signed [DATA_W-1:0] q_t;

  localparam q_t Q_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX,
    S_TD,
    S_DELTA,
    S_WB,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [SW-1:0] s;
    logic [AW-1:0] a;
    logic [SW-1:0] nxt;
    q_t            r;
    logic          term;
  } req_t;

  function automatic q_t sat(input logic signed [PW-1:0] v);
    if (v > Q_HI) return Q_HI[DATA_W-1:0];
    if (v < Q_LO) return Q_LO[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  function automatic logic signed [PW-1:0] sx(input q_t v);
    return {{(PW-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  state_t state_q, state_d;
  req_t   req_q, req_d;
  logic [AW-1:0] cnt_q, cnt_d;
  q_t max_q, max_d;
  q_t td_q, td_d;
  q_t upd_q_q, upd_q_d;
  logic signed [PW-1:0] delta_q, delta_d;

  q_t tbl_q [NUM_STATES][NUM_ACTIONS];
  q_t tbl_d [NUM_STATES][NUM_ACTIONS];

  q_t scan_v, old_v, new_v, max_eff;
  logic signed [PW-1:0] g_prod, a_prod;
  logic req_bad;

  always_comb begin
    scan_v  = tbl_q[req_q.nxt][cnt_q];
    old_v   = tbl_q[req_q.s][req_q.a];
    max_eff = req_q.term ? '0 : max_q;
    g_prod  = GAMMA_X * sx(max_eff);
    a_prod  = ALPHA_X * (sx(td_q) - sx(old_v));
    new_v   = sat(sx(old_v) + delta_q);
    req_bad = (int'(upd.upd_state) >= NUM_STATES)
           || (int'(upd.upd_next) >= NUM_STATES)
           || (int'(upd.upd_action) >= NUM_ACTIONS);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    td_d    = td_q;
    delta_d = delta_q;
    upd_q_d = upd_q_q;
    tbl_d   = tbl_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr) begin
          for (int i = 0; i < NUM_STATES; i++)
            for (int j = 0; j < NUM_ACTIONS; j++)
              tbl_d[i][j] = '0;
        end else if (upd.upd_valid) begin
          req_d.s    = upd.upd_state;
          req_d.a    = upd.upd_action;
          req_d.nxt  = upd.upd_next;
          req_d.r    = upd.upd_reward;
          req_d.term = upd.upd_terminal;
          cnt_d      = '0;
          max_d      = Q_MIN;
          state_d    = req_bad ? S_ERR : S_MAX;
        end
      end
      S_MAX: begin
        if (scan_v > max_q) max_d = scan_v;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CNT_END) state_d = S_TD;
      end
      S_TD: begin
        td_d    = sat(sx(req_q.r) + (g_prod >>> FRAC_W));
        state_d = S_DELTA;
      end
      S_DELTA: begin
        delta_d = a_prod >>> FRAC_W;
        state_d = S_WB;
      end
      S_WB: begin
        tbl_d[req_q.s][req_q.a] = new_v;
        upd_q_d = new_v;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      td_q    <= '0;
      delta_q <= '0;
      upd_q_q <= '0;
      for (int i = 0; i < NUM_STATES; i++)
        for (int j = 0; j < NUM_ACTIONS; j++)
          tbl_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      td_q    <= td_d;
      delta_q <= delta_d;
      upd_q_q <= upd_q_d;
      tbl_q   <= tbl_d;
    end
  end

  assign upd.upd_ready = (state_q == S_IDLE) && !clr;
  assign upd.upd_done  = (state_q == S_WB);
  assign upd.upd_err   = (state_q == S_ERR);
  assign upd.upd_q     = (state_q == S_WB) ? new_v : upd_q_q;
  assign busy          = (state_q != S_IDLE);

  q_t rd_bv;

  // Strict compare keeps the lowest index on ties
  always_comb begin
    rd_q    = '0;
    rd_best = '0;
    rd_bv   = '0;
    if (int'(rd_state) < NUM_STATES) begin
      if (int'(rd_action) < NUM_ACTIONS)
        rd_q = tbl_q[rd_state][rd_action];
      rd_bv = tbl_q[rd_state][0];
      for (int i = 1; i < NUM_ACTIONS; i++) begin
        if (tbl_q[rd_state][i] > rd_bv) begin
          rd_bv   = tbl_q[rd_state][i];
          rd_best = AW'(i);
        end
      end
    end
  end

endmodule

// File: doc/q_update_engine.md
# q_update_engine

Parametrised, multi-cycle Q-learning update engine for the maze agent. It owns the full Q-table in registers and accepts one update request at a time over a valid/ready handshake. For each request it scans the next-state row for max Q and computes `Q += alpha*(r + gamma*maxQ - Q)` in signed saturating fixed point, then writes back. It also exposes a combinational read/greedy-policy port for action selection. It sits between the maze environment/reward logic and the action-selection controller.

## Interface
- `NUM_STATES`, default 37: number of table rows (states).
- `NUM_ACTIONS`, default 4: number of table columns (actions); ≥2.
- `DATA_W`, default 32: signed two's-complement Q/reward width.
- `FRAC_W`, default 16: fractional bits of Q, reward, ALPHA and GAMMA.
- `ALPHA`, default 13107: learn rate, unsigned, FRAC_W fraction bits (0.2 at FRAC_W=16).
- `GAMMA`, default 58982: discount factor, unsigned, FRAC_W fraction bits (0.9 at FRAC_W=16).
- Derived widths: `SW = max(1, $clog2(NUM_STATES))`, `AW = max(1, $clog2(NUM_ACTIONS))`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous table clear; honoured only in IDLE.
- `upd_valid` in 1: update request valid.
- `upd_ready` out 1: engine can accept a request; `= (state==IDLE) && !clr`.
- `upd_state` in SW: state index s.
- `upd_action` in AW: action index a.
- `upd_next` in SW: next-state index s'.
- `upd_reward` in DATA_W: signed reward r, same Q format.
- `upd_terminal` in 1: s' is terminal; maxQ is forced to 0.
- `upd_done` out 1: one-cycle pulse; write-back occurs this cycle.
- `upd_err` out 1: one-cycle pulse; request dropped because an index is out of range.
- `upd_q` out DATA_W: new Q value; valid while `upd_done` is high, otherwise holds its last value.
- `busy` out 1: FSM is not in IDLE.
- `rd_state` in SW, `rd_action` in AW: read address.
- `rd_q` out DATA_W: combinational `Q[rd_state][rd_action]`; reads 0 when out of range.
- `rd_best` out AW: combinational argmax over row `rd_state`; the lowest index wins ties; 0 when out of range.

## Operation
- Storage is NUM_STATES×NUM_ACTIONS registers of DATA_W, all zero after reset or `clr`.
- FSM states: IDLE, MAX, TD, DELTA, WB, ERR.
- IDLE:
  - If `clr` is high, zero the table and ignore `upd_valid`.
  - Otherwise, on `upd_valid && upd_ready`, latch all `upd_*` inputs.
  - Go to ERR if s≥NUM_STATES, s'≥NUM_STATES or a≥NUM_ACTIONS; else go to MAX with index counter = 0 and max = most-negative.
- MAX: one action per cycle. `max = signed_max(max, Q[s'][i])` for i = 0..NUM_ACTIONS-1, taking NUM_ACTIONS cycles, then go to TD. If terminal, the scan still runs (fixed latency) and max is replaced by 0 at TD.
- TD: `td = sat(r + ((GAMMA*max) >>> FRAC_W))`.
  - The product is 2·DATA_W+1 bits, signed.
  - The shift is arithmetic (floor).
  - `sat` clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- DELTA: `delta = (ALPHA*(td - Q[s][a])) >>> FRAC_W`. The difference is DATA_W+1 bits; there is no intermediate truncation.
- WB:
  - `Q[s][a] = sat(old + delta)`.
  - `upd_q` = the new value.
  - `upd_done` = 1.
  - Go to IDLE.
  - When s==s', the scan uses pre-update values.
- ERR: `upd_err` = 1 for one cycle, no table write, then go to IDLE.
- The table is written only in WB or on `clr`. The read port shows the old value until the WB edge, and the new value from the next cycle.
- Reset asserted mid-operation aborts the request: no write, table zeroed, FSM returns to IDLE.

## Timing
- Reset values: `upd_ready`=1 (when `clr`=0), `upd_done`=0, `upd_err`=0, `upd_q`=0, `busy`=0, table = 0.
- Acceptance edge = cycle 0.
- MAX occupies cycles 1..NUM_ACTIONS.
- TD occupies cycle NUM_ACTIONS+1; DELTA occupies cycle NUM_ACTIONS+2.
- WB / `upd_done` occur in cycle NUM_ACTIONS+3 (7 at defaults).
- `upd_ready` is high again in cycle NUM_ACTIONS+4, which gives a throughput of one update per NUM_ACTIONS+4 cycles.
- An error request pulses `upd_err` in cycle 1; `upd_ready` returns in cycle 2.
- `upd_valid` may stay high across requests; each handshake is exactly one request.
- `clr` takes one cycle; the zeroed table is visible on `rd_q` the next cycle.

## Test plan
- **Basic update:** after reset, update (s=5, a=2, s'=6, r=0x000A0000, non-terminal) → `upd_done` at cycle 7, `upd_q` = `Q[5][2]` = 0x0001FFFE (131070); `rd_best` for s=5 is 2.
- **Discount path:** after update (6, 1, any s', r=0x000A0000, terminal) gives `Q[6][1]`=131070, update (5, 2, s'=6, r=0) with `Q[5][2]`=131070 → td=117962, delta=-2622, `Q[5][2]`=128448 (checks floor of a negative value).
- **Saturation:** 20 back-to-back updates (0, 0, s'=0, r=0x7FFF0000, non-terminal) → Q is monotonic non-decreasing, never exceeds 0x7FFFFFFF and never wraps negative. Repeat with r=0x80000000 → Q never drops below 0x80000000.
- **Argmax/ties:** make `Q[3][1]` and `Q[3][3]` equal positive values, others 0 → `rd_best`=1. Then a negative-reward update on a=1 → `rd_best`=3.
- **Error request:** `upd_state`=37 → `upd_err` in cycle 1, no `upd_done`, table unchanged, `upd_ready` high in cycle 2.
- **Control/reset:** assert `clr` with `upd_valid` high in IDLE → request not accepted and table all zero. Assert `rst` low during MAX of a request → no write, `busy`=0 immediately, all outputs at reset values.
